// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Stall vector bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb
    localparam logic [5:0] STALL_NONE = {NO_STOP, NO_STOP, NO_STOP, NO_STOP, NO_STOP, NO_STOP};
    localparam logic [5:0] STALL_ID   = {NO_STOP, NO_STOP, NO_STOP, STOP,    STOP,    STOP};
    localparam logic [5:0] STALL_EX   = {NO_STOP, NO_STOP, STOP,    STOP,    STOP,    STOP};
    localparam logic [5:0] STALL_MEM  = {NO_STOP, STOP,    STOP,    STOP,    STOP,    STOP};

    localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;
    localparam logic [31:0] BUS_ERR_VEC_DEF = 32'hBFC0_0380;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module pipeline_ctrl_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear, otherwise increment until all-ones and stick there.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: stall merge, exception/bus-timeout flush with
// PC redirect, data-bus watchdog and a saturating stall-cycle counter.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_RUN   | normal issue; stall vector follows the highest stall request
//  ST_FLUSH | one cycle: flush=1, new_pc valid, all requests ignored
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter logic [31:0] BUS_ERR_VEC = BUS_ERR_VEC_DEF,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stallreq_id_i,
    input  logic             stallreq_ex_i,
    input  logic             stallreq_mem_i,
    input  logic             excp_valid_i,
    input  logic [31:0]      excp_pc_i,
    input  logic             perf_clr_i,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic [31:0]      new_pc_o,
    output logic             bus_err_o,
    output logic [CNT_W-1:0] perf_stall_cnt_o
);

    localparam int unsigned   WD_W    = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    state_e          state_q;
    logic [WD_W-1:0] wd_q;
    logic            flush_q;
    logic            bus_err_q;
    logic [31:0]     new_pc_q;

    // Zero-latency stall merge; deepest requesting stage wins, nothing in FLUSH or reset.
    always_comb begin
        stall_o = STALL_NONE;
        if (rst_ni && (state_q == ST_RUN)) begin
            if (stallreq_mem_i) begin
                stall_o = STALL_MEM;
            end else if (stallreq_ex_i) begin
                stall_o = STALL_EX;
            end else if (stallreq_id_i) begin
                stall_o = STALL_ID;
            end
        end
    end

    // Sequencer FSM with watchdog; an exception outranks a bus timeout in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_RUN;
            wd_q      <= '0;
            flush_q   <= 1'b0;
            bus_err_q <= 1'b0;
            new_pc_q  <= ZERO_WORD;
        end else begin
            flush_q   <= 1'b0;
            bus_err_q <= 1'b0;
            wd_q      <= '0;
            case (state_q)
                ST_RUN: begin
                    if (excp_valid_i) begin
                        state_q  <= ST_FLUSH;
                        new_pc_q <= excp_pc_i;
                        flush_q  <= 1'b1;
                    end else if (stallreq_mem_i) begin
                        if (wd_q == WD_LAST) begin
                            state_q   <= ST_FLUSH;
                            new_pc_q  <= BUS_ERR_VEC;
                            flush_q   <= 1'b1;
                            bus_err_q <= 1'b1;
                        end else begin
                            wd_q <= wd_q + WD_W'(1);
                        end
                    end
                end
                ST_FLUSH: state_q <= ST_RUN;
                default:  state_q <= ST_RUN;
            endcase
        end
    end

    assign flush_o   = flush_q;
    assign bus_err_o = bus_err_q;
    assign new_pc_o  = new_pc_q;

    pipeline_ctrl_sat_counter #(
        .CNT_W(CNT_W)
    ) u_perf_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .inc_i (stall_o != STALL_NONE),
        .clr_i (perf_clr_i),
        .cnt_o (perf_stall_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl with a short watchdog and a 4-bit stall counter.
module tb_pipeline_ctrl;

    localparam int          T_CYC   = 4;
    localparam int          CW      = 4;
    localparam int          CNT_MAX = 15;
    localparam logic [31:0] BERR    = 32'hBFC00380;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_id, req_ex, req_mem, excp, clr;
    logic [31:0]   excp_pc;
    logic [5:0]    stall;
    logic          flush, bus_err;
    logic [31:0]   new_pc;
    logic [CW-1:0] cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: behaviour in terms of the rules, not the RTL's registers.
    bit          m_flush;
    bit          m_berr;
    logic [31:0] m_pc;
    int          m_mem_run;
    int          m_cnt;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .TIMEOUT_CYC(T_CYC),
        .BUS_ERR_VEC(BERR),
        .CNT_W      (CW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .stallreq_id_i   (req_id),
        .stallreq_ex_i   (req_ex),
        .stallreq_mem_i  (req_mem),
        .excp_valid_i    (excp),
        .excp_pc_i       (excp_pc),
        .perf_clr_i      (clr),
        .stall_o         (stall),
        .flush_o         (flush),
        .new_pc_o        (new_pc),
        .bus_err_o       (bus_err),
        .perf_stall_cnt_o(cnt)
    );

    function automatic logic [5:0] m_stall();
        if (!rst_n || m_flush) return 6'b000000;
        if (req_mem)           return 6'b011111;
        if (req_ex)            return 6'b001111;
        if (req_id)            return 6'b000111;
        return 6'b000000;
    endfunction

    function automatic logic [43:0] m_vec();
        return {m_stall(), m_flush, m_berr, m_pc, CW'(m_cnt)};
    endfunction

    task automatic m_reset();
        m_flush = 0; m_berr = 0; m_pc = 32'h0; m_mem_run = 0; m_cnt = 0;
    endtask

    task automatic set_in(input bit id, input bit ex, input bit mem,
                          input bit ev, input logic [31:0] pc, input bit c);
        req_id = id; req_ex = ex; req_mem = mem; excp = ev; excp_pc = pc; clr = c;
    endtask

    // Advance one clock (called at a negedge), updating the model at the posedge.
    task automatic tick();
        logic [5:0] s;
        s = m_stall();
        @(posedge clk);
        if (rst_n) begin
            if (clr)                               m_cnt = 0;
            else if (s != 0 && m_cnt < CNT_MAX)    m_cnt = m_cnt + 1;
            if (m_flush) begin
                m_flush = 0; m_berr = 0; m_mem_run = 0;
            end else if (excp) begin
                m_flush = 1; m_berr = 0; m_pc = excp_pc; m_mem_run = 0;
            end else if (req_mem) begin
                m_mem_run = m_mem_run + 1;
                if (m_mem_run == T_CYC) begin
                    m_flush = 1; m_berr = 1; m_pc = BERR; m_mem_run = 0;
                end
            end else begin
                m_mem_run = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1, 1, 1, 1, 32'h1234_5678, 0);
        m_reset();
        #2;
        checks++;
        if ({stall, flush, bus_err, new_pc, cnt} !== 44'h0) begin
            errors++;
            $display("FAIL reset: got stall=%b flush=%b berr=%b pc=%h cnt=%0d, want all zero",
                     stall, flush, bus_err, new_pc, cnt);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 32'h0, 0);
        #1;
        checks++;
        if ({stall, flush, bus_err, new_pc, cnt} !== 44'h0) begin
            errors++;
            $display("FAIL reset_release: got %h want 0", {stall, flush, bus_err, new_pc, cnt});
        end
        tick();
    endtask

    task automatic test_id_stall();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0, 0, 32'h0, 0);
            #1;
            checks++;
            if (stall !== 6'b000111) begin
                errors++;
                $display("FAIL id_stall cyc%0d: got %b want 000111", i, stall);
            end
            tick();
        end
        set_in(0, 0, 0, 0, 32'h0, 0);
        #1;
        checks++;
        if (stall !== 6'b000000 || cnt !== CW'(3)) begin
            errors++;
            $display("FAIL id_stall_cnt: got stall=%b cnt=%0d want 000000 cnt=3", stall, cnt);
        end
        tick();
    endtask

    task automatic test_priority();
        set_in(1, 1, 0, 0, 32'h0, 0);
        #1;
        checks++;
        if (stall !== 6'b001111) begin
            errors++;
            $display("FAIL prio_ex: got %b want 001111", stall);
        end
        tick();
        set_in(1, 1, 1, 0, 32'h0, 0);
        #1;
        checks++;
        if (stall !== 6'b011111) begin
            errors++;
            $display("FAIL prio_mem: got %b want 011111", stall);
        end
        tick();
        set_in(0, 0, 0, 0, 32'h0, 0);
        #1;
        checks++;
        if ({stall, flush, bus_err} !== 8'h00 || {stall, flush, bus_err, new_pc, cnt} !== m_vec()) begin
            errors++;
            $display("FAIL prio_idle: got %h want %h", {stall, flush, bus_err, new_pc, cnt}, m_vec());
        end
        tick();
    endtask

    task automatic test_exception();
        set_in(0, 0, 1, 1, 32'h80000180, 0);
        tick();
        set_in(1, 1, 1, 1, 32'h0BAD_0BAD, 0);
        #1;
        checks++;
        if (flush !== 1'b1 || new_pc !== 32'h80000180 || stall !== 6'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL excp_flush: got flush=%b pc=%h stall=%b berr=%b want 1 80000180 000000 0",
                     flush, new_pc, stall, bus_err);
        end
        tick();
        set_in(0, 0, 0, 0, 32'h0, 0);
        #1;
        checks++;
        if (flush !== 1'b0 || new_pc !== 32'h80000180) begin
            errors++;
            $display("FAIL excp_after: got flush=%b pc=%h want 0 80000180", flush, new_pc);
        end
        tick();
    endtask

    task automatic test_timeout();
        for (int i = 0; i < T_CYC; i++) begin
            set_in(0, 0, 1, 0, 32'h0, 0);
            #1;
            checks++;
            if (stall !== 6'b011111 || flush !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait cyc%0d: got stall=%b flush=%b want 011111 0", i, stall, flush);
            end
            tick();
        end
        #1;
        checks++;
        if (flush !== 1'b1 || bus_err !== 1'b1 || new_pc !== BERR || stall !== 6'b0) begin
            errors++;
            $display("FAIL timeout_hit: got flush=%b berr=%b pc=%h stall=%b want 1 1 %h 000000",
                     flush, bus_err, new_pc, stall, BERR);
        end
        set_in(0, 0, 0, 0, 32'h0, 0);
        tick();
        // Release before the limit: no bus error.
        for (int i = 0; i < T_CYC + 3; i++) begin
            set_in(0, 0, (i < T_CYC - 1), 0, 32'h0, 0);
            #1;
            checks++;
            if (bus_err !== 1'b0 || flush !== 1'b0) begin
                errors++;
                $display("FAIL timeout_release cyc%0d: got berr=%b flush=%b want 0 0", i, bus_err, flush);
            end
            tick();
        end
    endtask

    task automatic test_excp_on_timeout();
        for (int i = 0; i < T_CYC; i++) begin
            set_in(0, 0, 1, (i == T_CYC - 1), 32'h8000_0200, 0);
            tick();
        end
        set_in(0, 0, 0, 0, 32'h0, 0);
        #1;
        checks++;
        if (flush !== 1'b1 || bus_err !== 1'b0 || new_pc !== 32'h8000_0200) begin
            errors++;
            $display("FAIL excp_beats_timeout: got flush=%b berr=%b pc=%h want 1 0 80000200",
                     flush, bus_err, new_pc);
        end
        tick();
    endtask

    task automatic test_saturate();
        set_in(0, 0, 0, 0, 32'h0, 1);
        tick();
        for (int i = 0; i < 20; i++) begin
            set_in(1, 0, 0, 0, 32'h0, 0);
            tick();
        end
        set_in(1, 0, 0, 0, 32'h0, 1);
        #1;
        checks++;
        if (cnt !== CW'(CNT_MAX)) begin
            errors++;
            $display("FAIL cnt_saturate: got %0d want %0d", cnt, CNT_MAX);
        end
        tick();
        set_in(0, 0, 0, 0, 32'h0, 0);
        #1;
        checks++;
        if (cnt !== CW'(0)) begin
            errors++;
            $display("FAIL cnt_clear_wins: got %0d want 0", cnt);
        end
        tick();
    endtask

    task automatic test_reset_in_flush();
        set_in(1, 0, 0, 0, 32'h0, 0);
        tick();
        set_in(0, 0, 0, 1, 32'hA000_0040, 0);
        tick();
        set_in(1, 1, 1, 0, 32'h0, 0);
        #1;
        checks++;
        if (flush !== 1'b1) begin
            errors++;
            $display("FAIL rst_flush_setup: got flush=%b want 1", flush);
        end
        #1 rst_n = 1'b0;
        m_reset();
        #1;
        checks++;
        if ({stall, flush, bus_err, new_pc, cnt} !== 44'h0) begin
            errors++;
            $display("FAIL rst_in_flush: got stall=%b flush=%b berr=%b pc=%h cnt=%0d want all zero",
                     stall, flush, bus_err, new_pc, cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 32'h0, 0);
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0,
                   $urandom, $urandom_range(0, 31) == 0);
            #1;
            checks++;
            if ({stall, flush, bus_err, new_pc, cnt} !== m_vec()) begin
                errors++;
                $display("FAIL random cyc%0d: got stall=%b flush=%b berr=%b pc=%h cnt=%0d want %h",
                         i, stall, flush, bus_err, new_pc, cnt, m_vec());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_id_stall();
        test_priority();
        test_exception();
        test_timeout();
        test_excp_on_timeout();
        test_saturate();
        test_reset_in_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
